// File: rtl/player_input_ctrl_pkg.sv
// Shared definitions for the player input conditioning block.
//   DIR_*       : bit positions inside a 4-bit move bus
//   move_t      : 4-bit direction bus (one-hot or zero once resolved)
//   resolve_dir : single-direction resolution with held-direction priority
package player_input_ctrl_pkg;

    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_RIGHT = 3;

    localparam int unsigned NUM_PLAYERS = 2;

    typedef logic [3:0] move_t;

    // Keep the held direction while any of it is still pressed, otherwise
    // pick the lowest-numbered pressed direction (up beats down beats ...).
    function automatic move_t resolve_dir(move_t held, move_t deb);
        move_t res;
        res = '0;
        if ((held & deb) != '0) begin
            res = held;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (deb[i]) begin
                    res = '0;
                    res[i] = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/player_input_ctrl_debounce.sv
// button_debounce: two-flop synchroniser followed by a counter-based debouncer.
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset
//   raw_i    : asynchronous raw button level
//   stable_o : debounced level
//   rise_o   : one-cycle pulse in the first cycle stable_o is high
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;  // any agreeing cycle restarts the count
        if (sync2_q != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: conditions raw board buttons for both tanks.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   frame_tick_i          : one-cycle pulse per frame
//   p1/p2_move_raw_i      : raw direction buttons (bit0 up .. bit3 right)
//   p1/p2_shoot_raw_i     : raw fire buttons
//   player_1/2_move_o     : resolved direction, updated only after a frame tick
//   player_1/2_shoot_o    : one-cycle fire pulse, issued after a frame tick
//   shoot_ready_o         : bit n high when player n+1 has no cooldown left
module player_input_ctrl
    import player_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic [3:0] p1_move_raw_i,
    input  logic [3:0] p2_move_raw_i,
    input  logic       p1_shoot_raw_i,
    input  logic       p2_shoot_raw_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic [1:0] shoot_ready_o
);

    localparam int unsigned NumBtn = 10;
    localparam int unsigned CdW    = $clog2(COOLDOWN_FRAMES + 1);

    // Bits 3:0 P1 move, 7:4 P2 move, 8 P1 shoot, 9 P2 shoot.
    logic [NumBtn-1:0] raw, stable, rise;

    assign raw = {p2_shoot_raw_i, p1_shoot_raw_i, p2_move_raw_i, p1_move_raw_i};

    for (genvar b = 0; b < NumBtn; b++) begin : g_deb
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (raw[b]),
            .stable_o(stable[b]),
            .rise_o  (rise[b])
        );
    end

    // Move buttons only need the level, fire buttons only the press edge.
    logic unused_deb;
    assign unused_deb = ^{rise[7:0], stable[9:8]};

    move_t [NUM_PLAYERS-1:0]          move_q, move_d;
    logic  [NUM_PLAYERS-1:0]          pend_q, pend_d;
    logic  [NUM_PLAYERS-1:0]          shoot_q, shoot_d;
    logic  [NUM_PLAYERS-1:0][CdW-1:0] cd_q, cd_d;

    always_comb begin
        move_d  = move_q;
        pend_d  = pend_q;
        shoot_d = '0;
        cd_d    = cd_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            // Presses during cooldown are dropped, not queued.
            if (rise[8+p] && (cd_q[p] == '0)) begin
                pend_d[p] = 1'b1;
            end
            if (frame_tick_i) begin
                move_d[p] = resolve_dir(move_q[p], stable[p*4 +: 4]);
                // Uses the registered pending flag, so a press landing on the
                // tick cycle waits for the next tick.
                if (pend_q[p] && (cd_q[p] == '0)) begin
                    shoot_d[p] = 1'b1;
                    pend_d[p]  = 1'b0;
                    cd_d[p]    = CdW'(COOLDOWN_FRAMES);
                end else if (cd_q[p] != '0) begin
                    cd_d[p] = cd_q[p] - CdW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            move_q  <= '0;
            pend_q  <= '0;
            shoot_q <= '0;
            cd_q    <= '0;
        end else begin
            move_q  <= move_d;
            pend_q  <= pend_d;
            shoot_q <= shoot_d;
            cd_q    <= cd_d;
        end
    end

    always_comb begin
        shoot_ready_o = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            shoot_ready_o[p] = (cd_q[p] == '0);
        end
    end

    assign player_1_move_o  = move_q[0];
    assign player_2_move_o  = move_q[1];
    assign player_1_shoot_o = shoot_q[0];
    assign player_2_shoot_o = shoot_q[1];

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=3,
// frame tick during every cycle whose index mod 50 is 49.
module tb_player_input_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       frame_tick_i;
    logic [3:0] p1_move_raw_i, p2_move_raw_i;
    logic       p1_shoot_raw_i, p2_shoot_raw_i;
    logic [3:0] player_1_move_o, player_2_move_o;
    logic       player_1_shoot_o, player_2_shoot_o;
    logic [1:0] shoot_ready_o;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_FRAMES(3)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .frame_tick_i    (frame_tick_i),
        .p1_move_raw_i   (p1_move_raw_i),
        .p2_move_raw_i   (p2_move_raw_i),
        .p1_shoot_raw_i  (p1_shoot_raw_i),
        .p2_shoot_raw_i  (p2_shoot_raw_i),
        .player_1_move_o (player_1_move_o),
        .player_2_move_o (player_2_move_o),
        .player_1_shoot_o(player_1_shoot_o),
        .player_2_shoot_o(player_2_shoot_o),
        .shoot_ready_o   (shoot_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int p1_cnt = 0;
    int p2_cnt = 0;
    logic tick_prev = 1'b0;

    always @(negedge clk_i) begin
        if (player_1_shoot_o === 1'b1) p1_cnt++;
        if (player_2_shoot_o === 1'b1) p2_cnt++;
    end

    always @(posedge clk_i) begin
        assert (!(frame_tick_i && tick_prev)) else $error("frame tick wider than one cycle");
        tick_prev <= frame_tick_i;
    end

    typedef struct {
        logic [3:0] p1_raw;
        logic [3:0] p2_raw;
        logic [3:0] exp1;
        logic [3:0] exp2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        frame_tick_i = (cyc % 50 == 49);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int phase);
        while (cyc % 50 != phase) step();
    endtask

    task automatic next_frame();
        step();
        go_to(0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [3:0] prev1, prev2;
    int c1, c2, start_cyc;

    initial begin
        vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        vecs[1] = '{4'b1001, 4'b0110, 4'b0001, 4'b0010};
        vecs[2] = '{4'b1000, 4'b0110, 4'b1000, 4'b0010};
        vecs[3] = '{4'b1001, 4'b0100, 4'b1000, 4'b0100};
        vecs[4] = '{4'b0001, 4'b1100, 4'b0001, 4'b0100};
        vecs[5] = '{4'b1111, 4'b1011, 4'b0001, 4'b0001};
        vecs[6] = '{4'b0110, 4'b0000, 4'b0010, 4'b0000};
        vecs[7] = '{4'b0000, 4'b1111, 4'b0000, 4'b0001};

        reset_i = 1'b1;
        frame_tick_i = 1'b0;
        p1_move_raw_i = '0;
        p2_move_raw_i = '0;
        p1_shoot_raw_i = 1'b0;
        p2_shoot_raw_i = 1'b0;
        run(3);
        check("reset_ready_in_reset", int'(shoot_ready_o), 3);
        reset_i = 1'b0;
        step();
        check("reset_move1", int'(player_1_move_o), 0);
        check("reset_move2", int'(player_2_move_o), 0);
        check("reset_shoot1", int'(player_1_shoot_o), 0);
        check("reset_shoot2", int'(player_2_shoot_o), 0);
        check("reset_ready", int'(shoot_ready_o), 3);

        // Three-cycle glitch never becomes stable.
        go_to(10);
        p1_move_raw_i = 4'b0001;
        run(3);
        p1_move_raw_i = 4'b0000;
        go_to(0);
        check("glitch_tick1", int'(player_1_move_o), 0);
        next_frame();
        check("glitch_tick2", int'(player_1_move_o), 0);

        // Raw edge 6 cycles before the tick makes it, 5 cycles before does not.
        go_to(43);
        p2_move_raw_i = 4'b0010;
        step();
        p1_move_raw_i = 4'b0100;
        go_to(0);
        check("latency_in_time", int'(player_2_move_o), 2);
        check("latency_too_late", int'(player_1_move_o), 0);
        go_to(25);
        check("latency_midframe", int'(player_1_move_o), 0);
        go_to(0);
        check("latency_next_tick", int'(player_1_move_o), 4);

        // Resolution and frame latch table.
        prev1 = 4'b0100;
        prev2 = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            p1_move_raw_i = vecs[i].p1_raw;
            p2_move_raw_i = vecs[i].p2_raw;
            go_to(25);
            check($sformatf("vec%0d_mid1", i), int'(player_1_move_o), int'(prev1));
            check($sformatf("vec%0d_mid2", i), int'(player_2_move_o), int'(prev2));
            go_to(0);
            check($sformatf("vec%0d_move1", i), int'(player_1_move_o), int'(vecs[i].exp1));
            check($sformatf("vec%0d_move2", i), int'(player_2_move_o), int'(vecs[i].exp2));
            prev1 = vecs[i].exp1;
            prev2 = vecs[i].exp2;
        end
        p1_move_raw_i = '0;
        p2_move_raw_i = '0;
        next_frame();
        check("release_move1", int'(player_1_move_o), 0);
        check("release_move2", int'(player_2_move_o), 0);

        // Single shot then cooldown.
        c1 = p1_cnt;
        go_to(10);
        p1_shoot_raw_i = 1'b1;
        run(10);
        p1_shoot_raw_i = 1'b0;
        go_to(49);
        check("shot_before_tick", int'(player_1_shoot_o), 0);
        step();
        check("shot_pulse", int'(player_1_shoot_o), 1);
        check("shot_ready_low", int'(shoot_ready_o), 2);
        step();
        check("shot_one_cycle", int'(player_1_shoot_o), 0);
        go_to(10);
        p1_shoot_raw_i = 1'b1;
        run(10);
        p1_shoot_raw_i = 1'b0;
        go_to(0);
        check("cool_ready_t1", int'(shoot_ready_o), 2);
        go_to(10);
        p1_shoot_raw_i = 1'b1;
        run(10);
        p1_shoot_raw_i = 1'b0;
        go_to(0);
        check("cool_ready_t2", int'(shoot_ready_o), 2);
        // Press edge lands on the 3rd tick while cooldown is still 1: dropped.
        go_to(43);
        p1_shoot_raw_i = 1'b1;
        go_to(0);
        check("cool_ready_t3", int'(shoot_ready_o), 3);
        go_to(13);
        p1_shoot_raw_i = 1'b0;
        go_to(0);
        check("cool_discarded", p1_cnt - c1, 1);
        go_to(10);
        p1_shoot_raw_i = 1'b1;
        run(10);
        p1_shoot_raw_i = 1'b0;
        go_to(0);
        check("cool_refire", int'(player_1_shoot_o), 1);

        // P2 edge on the tick cycle is served one tick later.
        go_to(43);
        p2_shoot_raw_i = 1'b1;
        go_to(0);
        check("edge_on_tick_wait", int'(player_2_shoot_o), 0);
        go_to(10);
        p2_shoot_raw_i = 1'b0;
        go_to(0);
        check("edge_on_tick_fire", int'(player_2_shoot_o), 1);
        check("ready_both_cool", int'(shoot_ready_o), 0);
        next_frame();
        next_frame();
        check("ready_p2_cd1", int'(shoot_ready_o), 1);
        next_frame();
        check("ready_p2_back", int'(shoot_ready_o), 3);

        // No autofire on P1, P2 fires twice, first shots share a tick.
        c1 = p1_cnt;
        c2 = p2_cnt;
        go_to(10);
        start_cyc = cyc;
        p1_shoot_raw_i = 1'b1;
        p2_shoot_raw_i = 1'b1;
        run(10);
        p2_shoot_raw_i = 1'b0;
        go_to(0);
        check("same_tick_p1", int'(player_1_shoot_o), 1);
        check("same_tick_p2", int'(player_2_shoot_o), 1);
        next_frame();
        next_frame();
        next_frame();
        go_to(10);
        p2_shoot_raw_i = 1'b1;
        run(10);
        p2_shoot_raw_i = 1'b0;
        go_to(0);
        check("p2_second_shot", int'(player_2_shoot_o), 1);
        while (cyc < start_cyc + 400) step();
        p1_shoot_raw_i = 1'b0;
        for (int i = 0; i < 4; i++) next_frame();
        check("no_autofire_p1", p1_cnt - c1, 1);
        check("p2_two_shots", p2_cnt - c2, 2);
        check("indep_ready", int'(shoot_ready_o), 3);

        // Synchronous reset with cooldown 2, move held and P2 pending.
        go_to(10);
        p1_shoot_raw_i = 1'b1;
        p1_move_raw_i = 4'b0100;
        run(10);
        p1_shoot_raw_i = 1'b0;
        go_to(0);
        next_frame();
        check("pre_reset_move1", int'(player_1_move_o), 4);
        check("pre_reset_ready", int'(shoot_ready_o), 2);
        go_to(10);
        p2_shoot_raw_i = 1'b1;
        run(10);
        p2_shoot_raw_i = 1'b0;
        p1_move_raw_i = 4'b0000;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("mid_reset_move1", int'(player_1_move_o), 0);
        check("mid_reset_move2", int'(player_2_move_o), 0);
        check("mid_reset_shoot", int'({player_2_shoot_o, player_1_shoot_o}), 0);
        check("mid_reset_ready", int'(shoot_ready_o), 3);
        c2 = p2_cnt;
        go_to(0);
        step();
        check("reset_pend_cleared", p2_cnt - c2, 0);
        check("post_reset_move1", int'(player_1_move_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
